tristate_bus_arbiter: RTL and testbench

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

---
 rtl/tristate_bus_arbiter_pkg.sv | 19 +
 rtl/tristate_bus_arbiter_rr_picker.sv | 33 +++
 rtl/tristate_bus_arbiter.sv | 118 +++++++++++
 tb/tb_tristate_bus_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// rtl/tristate_bus_arbiter_pkg.sv - shared types and default constants for the tristate bus arbiter
package tristate_bus_arbiter_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_TURN_CYC  = 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  // Index width that stays at least one bit for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_picker.sv
// rtl/tristate_bus_arbiter_rr_picker.sv - combinational round-robin winner selection
module rr_picker
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_owner,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDW-1:0]     winner_idx,
  output logic               any_req
);

  int idx;

  // Scan from the requester after last_owner, wrapping, and take the first active one.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any_req    = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req     = 1'b1;
        winner_idx  = IDW'(idx);
        winner[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin owner arbitration for a shared tristate bus
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TURN_CYC  = DEF_TURN_CYC,   // must be at least 1
  localparam int IDW      = idx_width(NUM_REQ),
  localparam int BW       = $clog2(MAX_BURST + 1),
  localparam int TW       = $clog2(TURN_CYC + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] enable,
  output logic [IDW-1:0]     owner_id,
  output logic               bus_busy
);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDW-1:0]     owner_nxt;
  logic [IDW-1:0]     last_owner, last_nxt;
  logic [BW-1:0]      burst_cnt, burst_nxt;
  logic [TW-1:0]      turn_cnt, turn_nxt;

  logic [NUM_REQ-1:0] pick_winner;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .winner_idx (pick_idx),
    .any_req    (pick_any)
  );

  // Next-state logic: grant holds until the owner drops or the burst limit is hit,
  // then the bus is released for TURN_CYC dead cycles before re-arbitration.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner_id;
    last_nxt  = last_owner;
    burst_nxt = burst_cnt;
    turn_nxt  = turn_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          grant_nxt = pick_winner;
          owner_nxt = pick_idx;
          last_nxt  = pick_idx;
          burst_nxt = BW'(1);
        end
      end
      GRANT: begin
        if (!req[owner_id] || burst_cnt == BW'(MAX_BURST)) begin
          state_nxt = TURNAROUND;
          grant_nxt = '0;
          owner_nxt = '0;
          burst_nxt = '0;
          turn_nxt  = TW'(1);
        end else begin
          burst_nxt = burst_cnt + BW'(1);
        end
      end
      TURNAROUND: begin
        if (turn_cnt == TW'(TURN_CYC)) begin
          turn_nxt = '0;
          if (pick_any) begin
            state_nxt = GRANT;
            grant_nxt = pick_winner;
            owner_nxt = pick_idx;
            last_nxt  = pick_idx;
            burst_nxt = BW'(1);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          turn_nxt = turn_cnt + TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        owner_nxt = '0;
        burst_nxt = '0;
        turn_nxt  = '0;
      end
    endcase
  end

  // State and output registers; reset drops the drivers immediately, no turnaround.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner_id   <= '0;
      last_owner <= IDW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      turn_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      owner_id   <= owner_nxt;
      last_owner <= last_nxt;
      burst_cnt  <= burst_nxt;
      turn_cnt   <= turn_nxt;
    end
  end

  assign enable   = grant;
  assign bus_busy = (state != IDLE);

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - self-checking bench for tristate_bus_arbiter
module tb_tristate_bus_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;
  localparam int TC = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] enable;
  logic [1:0]   owner_id;
  logic         bus_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TURN_CYC(TC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .enable   (enable),
    .owner_id (owner_id),
    .bus_busy (bus_busy)
  );

  // Behavioural model: who owns the bus, how long it has held it, dead cycles left.
  int m_owner = -1;
  int m_held  = 0;
  int m_dead  = 0;
  int m_last  = N - 1;
  int m_w     = -1;
  bit m_valid = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1;
      m_held  = 0;
      m_dead  = 0;
      m_last  = N - 1;
      m_valid = 1'b1;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == MB) begin
        m_owner = -1;
        m_held  = 0;
        m_dead  = TC;
      end else begin
        m_held++;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else begin
      m_dead = 0;
      m_w = pick(req, m_last);
      if (m_w >= 0) begin
        m_owner = m_w;
        m_held  = 1;
        m_last  = m_w;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("grant",   grant,    (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("enable",  enable,   (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("owner",   owner_id, (m_owner >= 0) ? m_owner : 0);
      chk("busy",    bus_busy, (m_owner >= 0 || m_dead > 0) ? 1 : 0);
      chk("onehot",  ($countones(enable) <= 1) ? 1 : 0, 1);
      chk("en_eq_gr", (enable === grant) ? 1 : 0, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;

    repeat (2) begin
      tick();
      chk("rst_grant",  grant,    0);
      chk("rst_enable", enable,   0);
      chk("rst_busy",   bus_busy, 0);
    end

    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    chk("single_grant", grant,    4);
    chk("single_owner", owner_id, 2);
    chk("single_busy",  bus_busy, 1);
    tick();
    tick();
    chk("single_hold", grant, 4);
    req = 4'b0000;
    tick();
    chk("single_dead_grant", grant,    0);
    chk("single_dead_busy",  bus_busy, 1);
    tick();
    chk("single_idle_busy",  bus_busy, 0);
    chk("single_idle_grant", grant,    0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int o = 0; o < 4; o++) begin
      repeat (8) begin
        tick();
        chk("rr_grant", grant,    1 << o);
        chk("rr_owner", owner_id, o);
      end
      tick();
      chk("rr_dead",      grant,    0);
      chk("rr_dead_busy", bus_busy, 1);
    end
    tick();
    chk("rr_wrap_grant", grant,    1);
    chk("rr_wrap_owner", owner_id, 0);

    rst_n = 1'b0;
    req   = 4'b0001;
    tick();
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      chk("burst_a", grant, 1);
    end
    tick();
    chk("burst_dead", grant, 0);
    repeat (8) begin
      tick();
      chk("burst_b", grant, 1);
    end

    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
    req   = 4'b0010;
    tick();
    tick();
    tick();
    chk("midrst_owner", owner_id, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_enable", enable,   0);
    chk("midrst_busy",   bus_busy, 0);
    rst_n = 1'b1;
    req   = 4'b0011;
    tick();
    chk("midrst_regrant", grant,    1);
    chk("midrst_owner0",  owner_id, 0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end

    rst_n = 1'b1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
